serial_responder: RTL and testbench

SERIAL_RESPONDER -- requirements
Module: serial_responder

---
 rtl/serial_responder_if.sv | 25 ++
 rtl/serial_responder.sv | 147 ++++++++++++++
 tb/tb_serial_responder.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/serial_responder_if.sv
// Serial request/reply links plus status outputs of serial_responder.
// master = remote requester / bench, slave = the responder itself.
interface serial_responder_if #(parameter int WIDTH = 16);
  logic             rxSerialClock;
  logic             rxSerialData;
  logic             txSerialClock;
  logic             txSerialData;
  logic             busy;
  logic             frameReceived;
  logic             replySent;
  logic [WIDTH-1:0] checksum;
  logic [7:0]       droppedFrames;

  modport master (
    output rxSerialClock, rxSerialData,
    input  txSerialClock, txSerialData, busy, frameReceived, replySent,
           checksum, droppedFrames
  );

  modport slave (
    input  rxSerialClock, rxSerialData,
    output txSerialClock, txSerialData, busy, frameReceived, replySent,
           checksum, droppedFrames
  );
endinterface

// File: rtl/serial_responder.sv
// Serial responder: locks on SFD 0xAB, stores 2^LOGSIZE words, then replies
// with SFD, the stored words and their checksum. Assumes WIDTH >= 8, LOGSIZE >= 1.
module serial_responder #(
  parameter int WIDTH   = 16,
  parameter int LOGSIZE = 1
) (
  input  logic                clock,
  input  logic                resetN,
  serial_responder_if.slave   bus
);
  localparam int         NW  = 1 << LOGSIZE;
  localparam int         BW  = $clog2(WIDTH);
  localparam logic [7:0] SFD = 8'hAB;

  typedef enum logic [2:0] {SEEK, RECEIVE, TURNAROUND, SEND_SFD, SEND_DATA, SEND_SUM} state_t;

  state_t                   r_state, w_next;
  logic [5:0]               r_hist;
  logic                     r_stb, r_bit;
  logic [7:0]               r_seek;
  logic [LOGSIZE-1:0]       r_widx;
  logic [BW-1:0]            r_bidx;
  logic [NW-1:0][WIDTH-1:0] r_buf;
  logic [WIDTH-1:0]         r_sum;
  logic                     r_frame, r_sent;
  logic [7:0]               r_drop;
  logic [3:0]               r_phase;   // turnaround count, then per-bit phase

  logic [5:0]       w_hist_sh;
  logic [7:0]       w_seek_sh;
  logic             w_match, w_last_rx, w_bit_end, w_last_tx, w_send, w_txbit, w_txclk;
  logic [WIDTH-1:0] w_sum;

  assign w_hist_sh = {r_hist[4:0], bus.rxSerialClock};
  assign w_seek_sh = {r_seek[6:0], r_bit};
  assign w_match   = r_stb && (w_seek_sh == SFD);
  assign w_last_rx = r_stb && (r_state == RECEIVE) && (r_bidx == '0) &&
                     (r_widx == LOGSIZE'(NW-1));
  assign w_bit_end = (r_phase == 4'hF);
  assign w_last_tx = (r_state == SEND_SUM) && w_bit_end && (r_bidx == '0);
  assign w_send    = (r_state == SEND_SFD) || (r_state == SEND_DATA) || (r_state == SEND_SUM);

  // Checksum includes the bit being stored this cycle so it is ready with frameReceived
  always_comb begin
    w_sum = '0;
    for (int i = 0; i < NW-1; i++) w_sum += r_buf[i];
    w_sum += {r_buf[NW-1][WIDTH-1:1], r_bit};
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      SEEK:       if (w_match) w_next = RECEIVE;
      RECEIVE:    if (w_last_rx) w_next = TURNAROUND;
      TURNAROUND: if (r_phase == 4'hF) w_next = SEND_SFD;
      SEND_SFD:   if (w_bit_end && r_bidx == '0) w_next = SEND_DATA;
      SEND_DATA:  if (w_bit_end && r_bidx == '0 && r_widx == LOGSIZE'(NW-1)) w_next = SEND_SUM;
      SEND_SUM:   if (w_last_tx) w_next = SEEK;
      default:    w_next = SEEK;
    endcase
  end

  always_comb begin
    w_txbit = 1'b0;
    case (r_state)
      SEND_SFD:  w_txbit = SFD[r_bidx[2:0]];
      SEND_DATA: w_txbit = r_buf[r_widx][r_bidx];
      SEND_SUM:  w_txbit = r_sum[r_bidx];
      default:   w_txbit = 1'b0;
    endcase
  end

  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) r_state <= SEEK;
    else         r_state <= w_next;
  end

  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      r_hist <= '0; r_stb <= 1'b0; r_bit <= 1'b0; r_seek <= '0;
      r_widx <= '0; r_bidx <= '0; r_buf <= '0; r_sum <= '0;
      r_frame <= 1'b0; r_sent <= 1'b0; r_drop <= '0; r_phase <= '0;
    end else begin
      r_hist  <= w_hist_sh;
      r_stb   <= 1'b0;
      r_frame <= 1'b0;
      r_sent  <= 1'b0;
      if (&w_hist_sh) begin
        r_hist <= '0;
        r_stb  <= 1'b1;
        r_bit  <= bus.rxSerialData;
      end
      // Seek register keeps hunting outside RECEIVE; a match while busy is a drop
      if (r_stb && r_state != RECEIVE) r_seek <= w_match ? '0 : w_seek_sh;
      if (w_match && r_state != SEEK && r_state != RECEIVE && r_drop != 8'hFF)
        r_drop <= r_drop + 8'd1;
      case (r_state)
        SEEK: if (w_match) begin
          r_widx <= '0;
          r_bidx <= BW'(WIDTH-1);
        end
        RECEIVE: if (r_stb) begin
          r_buf[r_widx][r_bidx] <= r_bit;
          if (r_bidx == '0) begin
            r_bidx <= BW'(WIDTH-1);
            r_widx <= r_widx + 1'b1;
          end else begin
            r_bidx <= r_bidx - 1'b1;
          end
          if (w_last_rx) begin
            r_sum   <= w_sum;
            r_frame <= 1'b1;
            r_phase <= '0;
          end
        end
        TURNAROUND: begin
          r_phase <= r_phase + 4'd1;
          if (r_phase == 4'hF) r_bidx <= BW'(7);
        end
        default: begin
          r_phase <= r_phase + 4'd1;
          if (w_bit_end) begin
            if (r_bidx == '0) begin
              r_bidx <= BW'(WIDTH-1);
              if (r_state == SEND_DATA) r_widx <= r_widx + 1'b1;
              if (w_last_tx) begin
                r_sent <= 1'b1;
                r_seek <= '0;
              end
            end else begin
              r_bidx <= r_bidx - 1'b1;
            end
          end
        end
      endcase
    end
  end

  assign w_txclk           = w_send && !r_phase[3];
  assign bus.txSerialClock = w_txclk;
  assign bus.txSerialData  = w_txclk && w_txbit;
  assign bus.busy          = (r_state != SEEK) || r_sent;
  assign bus.frameReceived = r_frame;
  assign bus.replySent     = r_sent;
  assign bus.checksum      = r_sum;
  assign bus.droppedFrames = r_drop;
endmodule

// File: tb/tb_serial_responder.sv
// Self-checking bench for serial_responder: table vectors, randomized frames
// against a bit-stream model, and hand-built drop / reset / sampler sequences.
module tb_serial_responder;
  logic clock  = 1'b0;
  logic resetN = 1'b0;

  serial_responder_if #(.WIDTH(16)) bus();
  serial_responder #(.WIDTH(16), .LOGSIZE(1)) dut (.clock(clock), .resetN(resetN), .bus(bus));

  always #5 clock = ~clock;

  typedef struct { logic [15:0] w0; logic [15:0] w1; logic [15:0] sum; } vec_t;

  int   checks = 0, failures = 0;
  int   cyc = 0, n_frame = 0, n_sent = 0, frame_cyc = 0, sent_cyc = 0, tx_bad = 0;
  bit   tx_bits[$];
  int   tx_cyc[$];
  logic prev_tx = 1'b0, cur_bit = 1'b0;
  bit   req[$];
  int   bf, bs, bb;

  always @(posedge clock) cyc++;

  // Reply monitor: one bit per txSerialClock rise, plus link-shape sanity
  always @(negedge clock) begin
    if (bus.txSerialClock && !prev_tx) begin
      tx_bits.push_back(bus.txSerialData);
      tx_cyc.push_back(cyc);
      cur_bit = bus.txSerialData;
    end else if (bus.txSerialClock && bus.txSerialData !== cur_bit) begin
      tx_bad++;
    end
    if (!bus.txSerialClock && bus.txSerialData) tx_bad++;
    prev_tx = bus.txSerialClock;
    if (bus.frameReceived) begin n_frame++; frame_cyc = cyc; end
    if (bus.replySent)     begin n_sent++;  sent_cyc  = cyc; end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic send_bit(input bit b, input int hi, input int lo);
    bus.rxSerialData  = b;
    bus.rxSerialClock = 1'b1;
    repeat (hi) @(negedge clock);
    bus.rxSerialClock = 1'b0;
    bus.rxSerialData  = 1'b0;
    repeat (lo) @(negedge clock);
  endtask

  task automatic push_byte(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) req.push_back(b[i]);
  endtask

  task automatic push_word(input logic [15:0] w);
    for (int i = 15; i >= 0; i--) req.push_back(w[i]);
  endtask

  task automatic send_req(input int hi, input int lo);
    foreach (req[i]) send_bit(req[i], hi, lo);
    req.delete();
  endtask

  task automatic begin_frame();
    bf = n_frame; bs = n_sent; bb = tx_bits.size();
  endtask

  task automatic end_frame(input logic [15:0] w0, input logic [15:0] w1,
                           input logic [15:0] sum, input string name);
    int t;
    logic [55:0] got;
    t = 0;
    while (n_sent == bs && t < 3000) begin @(negedge clock); t++; end
    @(negedge clock);
    check($sformatf("%s replySent", name), n_sent - bs, 1);
    check($sformatf("%s frameReceived", name), n_frame - bf, 1);
    check($sformatf("%s checksum", name), bus.checksum, sum);
    got = '0;
    if (tx_bits.size() >= bb + 56)
      for (int i = 0; i < 56; i++) got = {got[54:0], tx_bits[bb+i]};
    check($sformatf("%s reply", name), got, {8'hAB, w0, w1, sum});
    if (tx_bits.size() > bb) begin
      check($sformatf("%s turnaround", name), tx_cyc[bb] - frame_cyc, 16);
      check($sformatf("%s reply length", name), sent_cyc - tx_cyc[bb], 896);
    end
    check($sformatf("%s idle busy", name), bus.busy, 0);
  endtask

  // Model of the request link: lock on the first 0xAB window of the bit stream
  task automatic build_random(output logic [15:0] w0, output logic [15:0] w1);
    bit [7:0] win;
    int n;
    win = '0;
    n = $urandom_range(0, 16);
    for (int i = 0; i < n; i++) req.push_back($urandom_range(0, 1) != 0);
    push_byte(8'hAB);
    for (int i = 0; i < req.size(); i++) begin
      win = {win[6:0], req[i]};
      if (win == 8'hAB) begin
        while (req.size() > i + 1) void'(req.pop_back());
        break;
      end
    end
    w0 = 16'($urandom);
    w1 = 16'($urandom);
    push_word(w0);
    push_word(w1);
  endtask

  initial begin
    vec_t        tbl[5];
    logic [15:0] w0, w1, s;
    int          t, sfd, guard, bs2;

    tbl[0] = '{16'h1234, 16'h00FF, 16'h1333};
    tbl[1] = '{16'hFFFF, 16'h0002, 16'h0001};
    tbl[2] = '{16'h0000, 16'h0000, 16'h0000};
    tbl[3] = '{16'hABAB, 16'h00AB, 16'hAC56};
    tbl[4] = '{16'h7FFF, 16'h0001, 16'h8000};

    bus.rxSerialClock = 1'b0;
    bus.rxSerialData  = 1'b0;
    repeat (3) @(negedge clock);
    check("reset txSerialClock", bus.txSerialClock, 0);
    check("reset txSerialData", bus.txSerialData, 0);
    check("reset busy", bus.busy, 0);
    check("reset frameReceived", bus.frameReceived, 0);
    check("reset replySent", bus.replySent, 0);
    check("reset checksum", bus.checksum, 0);
    check("reset droppedFrames", bus.droppedFrames, 0);
    resetN = 1'b1;
    @(negedge clock);

    for (int v = 0; v < 5; v++) begin
      begin_frame();
      push_byte(8'hAB); push_word(tbl[v].w0); push_word(tbl[v].w1);
      send_req(8, 8);
      end_frame(tbl[v].w0, tbl[v].w1, tbl[v].sum, $sformatf("vec%0d", v));
    end

    for (int r = 0; r < 5; r++) begin
      build_random(w0, w1);
      s = w0 + w1;
      begin_frame();
      send_req($urandom_range(6, 11), $urandom_range(1, 8));
      end_frame(w0, w1, s, $sformatf("rand%0d", r));
    end

    // Alternating preamble; a 5-cycle clock pulse must not count as a bit
    begin_frame();
    for (int i = 0; i < 11; i++) req.push_back(i % 2 == 0);
    send_req(8, 8);
    check("preamble busy", bus.busy, 0);
    send_bit(1'b1, 5, 8);
    check("short pulse ignored", bus.busy, 0);
    send_bit(1'b1, 8, 8);
    check("lock after final 1", bus.busy, 1);
    push_word(16'h1111); push_word(16'h2222);
    send_req(8, 8);
    end_frame(16'h1111, 16'h2222, 16'h3333, "preamble");

    // Full request arriving during SEND_DATA is dropped
    begin_frame();
    push_byte(8'hAB); push_word(16'h1234); push_word(16'h00FF);
    send_req(8, 8);
    t = 0;
    while (tx_bits.size() < bb + 9 && t < 2000) begin @(negedge clock); t++; end
    check("reached SEND_DATA", t < 2000, 1);
    push_byte(8'hAB); push_word(16'h0000); push_word(16'h0000);
    send_req(8, 8);
    check("one drop", bus.droppedFrames, 1);
    end_frame(16'h1234, 16'h00FF, 16'h1333, "drop1");

    // Many SFDs while busy: counter saturates at 255
    sfd = 1;
    guard = 0;
    while (sfd < 300 && guard < 60) begin
      guard++;
      begin_frame();
      push_byte(8'hAB); push_word(16'h0000); push_word(16'h0000);
      send_req(6, 1);
      @(negedge clock);
      while (sfd < 300 && cyc + 64 < frame_cyc + 912) begin
        push_byte(8'hAB);
        send_req(6, 1);
        sfd++;
      end
      end_frame(16'h0000, 16'h0000, 16'h0000, $sformatf("sat%0d", guard));
      check($sformatf("sat%0d droppedFrames", guard), bus.droppedFrames, (sfd > 255) ? 255 : sfd);
    end
    check("saturated 255", bus.droppedFrames, 255);

    // Reset in the middle of reply bit 20
    begin_frame();
    push_byte(8'hAB); push_word(16'hCAFE); push_word(16'h0101);
    send_req(8, 8);
    t = 0;
    while (tx_bits.size() <= bb + 20 && t < 2000) begin @(negedge clock); t++; end
    #2;
    check("bit20 tx high", bus.txSerialClock, 1);
    resetN = 1'b0;
    #1;
    check("async rst txSerialClock", bus.txSerialClock, 0);
    check("async rst txSerialData", bus.txSerialData, 0);
    check("async rst busy", bus.busy, 0);
    check("async rst checksum", bus.checksum, 0);
    check("async rst droppedFrames", bus.droppedFrames, 0);
    repeat (3) @(negedge clock);
    resetN = 1'b1;
    bs2 = n_sent;
    repeat (1000) @(negedge clock);
    check("no replySent after abort", n_sent - bs2, 0);
    check("no replySent at all", n_sent - bs, 0);

    begin_frame();
    push_byte(8'hAB); push_word(16'h0F0F); push_word(16'hF0F1);
    send_req(8, 8);
    end_frame(16'h0F0F, 16'hF0F1, 16'h0000, "after reset");

    check("tx link shape", tx_bad, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
